// File: rtl/hilo_mul_sequencer.sv
// Iterative HI/LO multiply unit: shift-add multiply of operand magnitudes, sign fix-up and
// accumulate into {HI,LO} in a final cycle, with pipeline stall and flush handling.
module hilo_mul_sequencer #(
   parameter int WIDTH        = 32,
   parameter int BITS_PER_CYC = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   input  logic             HiLoRead,
   output logic             Busy,
   output logic             Done,
   output logic             Stall,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);
   localparam int CYCLES = WIDTH / BITS_PER_CYC;
   localparam int CNT_W  = $clog2(CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_MADD  = 3'b010;
   localparam logic [2:0] OP_MSUB  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic                        signed_op_s;
   logic [WIDTH-1:0]            mag_a_s, mag_b_s;
   logic [WIDTH+BITS_PER_CYC-1:0] partial_s, upper_s;
   logic [2*WIDTH-1:0]          prod_step_s, prod_fix_s, hilo_s;
   logic                        busy_s;

   // Operand magnitudes and one shift-add step; the low half of prod_q holds the unretired multiplier bits.
   always_comb begin
      signed_op_s = (Op != OP_MULTU);
      mag_a_s     = (signed_op_s && A[WIDTH-1]) ? -A : A;
      mag_b_s     = (signed_op_s && B[WIDTH-1]) ? -B : B;
      partial_s   = {{BITS_PER_CYC{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_q[BITS_PER_CYC-1:0]};
      upper_s     = {{BITS_PER_CYC{1'b0}}, prod_q[2*WIDTH-1:WIDTH]} + partial_s;
      prod_step_s = {upper_s, prod_q[WIDTH-1:BITS_PER_CYC]};
      prod_fix_s  = neg_q ? -prod_q : prod_q;
      hilo_s      = {hi_q, lo_q};
   end

   // Next-state and datapath update; Flush overrides everything including the FIX write.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      neg_d   = neg_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      if (Flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  case (Op)
                     OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                        state_d = ST_MUL;
                        op_d    = Op;
                        neg_d   = signed_op_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                        mcand_d = mag_a_s;
                        prod_d  = {{WIDTH{1'b0}}, mag_b_s};
                        count_d = CNT_W'(CYCLES);
                     end
                     OP_MTHI: hi_d = A;
                     OP_MTLO: lo_d = A;
                     default: state_d = ST_IDLE;
                  endcase
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL: begin
               prod_d  = prod_step_s;
               count_d = count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = ST_MUL;
               end
            end
            ST_FIX: begin
               case (op_q)
                  OP_MADD: {hi_d, lo_d} = hilo_s + prod_fix_s;
                  OP_MSUB: {hi_d, lo_d} = hilo_s - prod_fix_s;
                  default: {hi_d, lo_d} = prod_fix_s;
               endcase
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         op_q    <= 3'b000;
         neg_q   <= 1'b0;
         mcand_q <= {WIDTH{1'b0}};
         prod_q  <= {(2*WIDTH){1'b0}};
         count_q <= {CNT_W{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy_s = (state_q != ST_IDLE);
   assign Busy   = busy_s;
   assign Done   = done_q;
   assign Stall  = busy_s & (Start | HiLoRead);
   assign Hi     = hi_q;
   assign Lo     = lo_q;

endmodule
